clk_div_meter: RTL
==================

Name: clk_div_meter

Overview:
Measures a divided clock that is produced from CLK_Ref, such as the clock divider output, by sampling it as data on rising CLK_Ref.
- Reports period and high time in reference cycles.
- Flags lock when the period is stable and flags a stuck input.
- Used on-chip as the checking end of the divider interface, for self-test and for confirming the division ratio before UART traffic is enabled.

Parameters:
CNT_W, 8, width of period/high-time counters; saturation value is 2^CNT_W-1
LOCK_CNT, 4, consecutive identical periods required to assert Locked

Ports:
CLK_Ref  in  1  reference clock
Reset  in  1  synchronous, active-high reset
Meas_EN  in  1  enable measurement; low forces IDLE
Sig_in  in  1  divided clock, sampled as data on rising CLK_Ref (same domain, no synchroniser)
Period  out  CNT_W  last measured period, in CLK_Ref cycles
High_time  out  CNT_W  samples of Sig_in=1 within the last period
Meas_valid  out  1  one-cycle pulse when Period/High_time update
Locked  out  1  LOCK_CNT consecutive equal periods seen
Stuck  out  1  no rising edge within 2^CNT_W-1 cycles

Behaviour:
- One clock, CLK_Ref. Reset is synchronous and active-high.
- Reset (also mid-operation): state=IDLE; all outputs 0; counters 0; sig_q=0; match count 0.
- Edge detect: sig_q <= Sig_in every cycle; rise = Sig_in & ~sig_q.
- FSM:
  - IDLE: if Meas_EN, go to ARM.
  - ARM: on rise, go to MEASURE with cnt<=1, hcnt<=1; no Meas_valid.
  - MEASURE: on rise, Period<=cnt, High_time<=hcnt, Meas_valid=1 next cycle-edge (registered, same edge as Period update), then cnt<=1, hcnt<=1.
  - MEASURE, no rise: cnt<=cnt+1 and hcnt<=hcnt+Sig_in, both saturating at 2^CNT_W-1.
- Stuck:
  - In MEASURE, cnt reaching 2^CNT_W-1 without a rise sets Stuck=1, Locked=0, match count 0, returns to ARM.
  - Period/High_time hold their values.
  - Stuck clears on the next rise.
  - In ARM, a separate wait counter applies the same timeout.
- Lock:
  - On each valid measurement, if new Period==previous Period, match count increments (saturating at LOCK_CNT); otherwise it resets to 1.
  - Locked=1 while match count >= LOCK_CNT.
  - Mismatch, Stuck or Meas_EN=0 clears Locked in the same cycle as the registered update.
  - The first measurement after ARM never counts as a match.
- Meas_EN low in any state: go to IDLE next edge; Locked=0, Stuck=0, Meas_valid=0; Period/High_time hold.
- Rise coinciding with Meas_EN falling: Meas_EN wins; no update.
- Sig_in constant, including a divider in bypass (div 0/1 passing CLK_Ref, which samples constant): no rise, so Stuck after timeout.
- Latency: Period/Meas_valid are visible the cycle after the rising CLK_Ref edge that samples the Sig_in rise.

Optional Feature:
DUTY_CHECK_EN
- Defined:
  - Adds output Duty_err (1 bit, reset 0), updated with each Meas_valid.
  - Duty_err=1 when |2*High_time - Period| > 1, computed at CNT_W+1 bits.
  - Duty_err clears when Meas_EN=0.
- Undefined: port and logic absent; all other behaviour unchanged.

Decomposition:
- Package clk_meter_pkg holds:
  - state encoding (IDLE/ARM/MEASURE);
  - default CNT_W and LOCK_CNT;
  - saturation-value function.
- One sub-module, rise_detect (registered sample plus rise output), reused for Sig_in.
- Counters and FSM stay in the top.

Test Plan:
- Reset, Meas_EN=1, Sig_in = divide-by-2 waveform (1,0 repeating) -> first Meas_valid on the 2nd rise; Period=2, High_time=1; Locked=1 after 4 equal periods.
- Divide-by-5 (high 2, low 3) -> Period=5, High_time=2; with DUTY_CHECK_EN, Duty_err=0; with high 1/low 4, Duty_err=1.
- Switch Sig_in from divide-by-4 to divide-by-7 while Locked -> Locked drops on the first Period=7 measurement and reasserts after 4 equal periods.
- Sig_in held 0 in MEASURE -> Stuck=1 exactly 255 cycles after the last rise; Period holds; next rise clears Stuck with no Meas_valid (ARM).
- Meas_EN=0 mid-period, then re-enabled -> Locked=0, no Meas_valid until the 2nd rise after re-enable.
- Reset asserted mid-MEASURE -> all outputs 0 the next cycle, state IDLE, Period=0.

Source files
------------

// File: rtl/clk_meter_pkg.sv
// clk_meter_pkg: state encoding, default sizes and saturation helper shared by clk_div_meter.
package clk_meter_pkg;
    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
    localparam int CNT_W_DEF = 8;
    localparam int LOCK_CNT_DEF = 4;
    function automatic int sat_val(input int w);
        return (1 << w) - 1;
    endfunction
endpackage

// File: rtl/clk_div_meter_rise_detect.sv
// rise_detect: registered sample of a same-domain signal plus its rising-edge strobe.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic q;
    always_ff @(posedge clk) q <= rst ? 1'b0 : d;
    assign rise = d & ~q;
endmodule

// File: rtl/clk_div_meter.sv
// clk_div_meter: measures period/high time of a CLK_Ref-derived divided clock with lock and stuck flags.
// Optional duty-cycle error output Duty_err is enabled by defining DUTY_CHECK_EN.
module clk_div_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic             CLK_Ref,
    input  logic             Reset,
    input  logic             Meas_EN,
    input  logic             Sig_in,
    output logic [CNT_W-1:0] Period,
    output logic [CNT_W-1:0] High_time,
    output logic             Meas_valid,
    output logic             Locked,
`ifdef DUTY_CHECK_EN
    output logic             Stuck,
    output logic             Duty_err
`else
    output logic             Stuck
`endif
);
    localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_val(CNT_W));
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0] LOCK_V = MW'(LOCK_CNT);

    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, hcnt, hcnt_n, wcnt, wcnt_n, period_n, high_n;
    logic [MW-1:0] match, match_n;
    logic valid_n, locked_n, stuck_n, rise;

    rise_detect u_rise (.clk(CLK_Ref), .rst(Reset), .d(Sig_in), .rise(rise));

`ifdef DUTY_CHECK_EN
    logic [CNT_W:0] dbl_high, ext_per, duty_diff;
    logic duty_n;
    assign dbl_high  = {hcnt, 1'b0};
    assign ext_per   = {1'b0, cnt};
    assign duty_diff = dbl_high > ext_per ? dbl_high - ext_per : ext_per - dbl_high;
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        hcnt_n   = hcnt;
        wcnt_n   = '0;
        period_n = Period;
        high_n   = High_time;
        valid_n  = 1'b0;
        locked_n = Locked;
        stuck_n  = Stuck;
        match_n  = match;
`ifdef DUTY_CHECK_EN
        duty_n   = Duty_err;
`endif
        if (!Meas_EN) begin
            state_n  = IDLE;
            locked_n = 1'b0;
            stuck_n  = 1'b0;
            match_n  = '0;
`ifdef DUTY_CHECK_EN
            duty_n   = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: state_n = ARM;
                ARM: begin
                    if (rise) begin
                        state_n = MEASURE;
                        cnt_n   = CNT_W'(1);
                        hcnt_n  = CNT_W'(1);
                        stuck_n = 1'b0;
                        match_n = '0;
                    end else begin
                        wcnt_n = wcnt == SAT ? SAT : wcnt + 1'b1;
                        if (wcnt == SAT) begin
                            stuck_n  = 1'b1;
                            locked_n = 1'b0;
                            match_n  = '0;
                        end
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_n = cnt;
                        high_n   = hcnt;
                        valid_n  = 1'b1;
                        cnt_n    = CNT_W'(1);
                        hcnt_n   = CNT_W'(1);
                        // match==0 marks the first measurement after ARM, which never counts
                        match_n  = (match != '0 && cnt == Period) ? (match == LOCK_V ? match : match + 1'b1) : MW'(1);
                        locked_n = match_n >= LOCK_V;
`ifdef DUTY_CHECK_EN
                        duty_n   = duty_diff > (CNT_W+1)'(1);
`endif
                    end else if (cnt == SAT) begin
                        state_n  = ARM;
                        stuck_n  = 1'b1;
                        locked_n = 1'b0;
                        match_n  = '0;
                    end else begin
                        cnt_n  = cnt + 1'b1;
                        hcnt_n = hcnt == SAT ? hcnt : hcnt + CNT_W'(Sig_in);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_Ref) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            hcnt       <= '0;
            wcnt       <= '0;
            match      <= '0;
            Period     <= '0;
            High_time  <= '0;
            Meas_valid <= 1'b0;
            Locked     <= 1'b0;
            Stuck      <= 1'b0;
`ifdef DUTY_CHECK_EN
            Duty_err   <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            hcnt       <= hcnt_n;
            wcnt       <= wcnt_n;
            match      <= match_n;
            Period     <= period_n;
            High_time  <= high_n;
            Meas_valid <= valid_n;
            Locked     <= locked_n;
            Stuck      <= stuck_n;
`ifdef DUTY_CHECK_EN
            Duty_err   <= duty_n;
`endif
        end
    end
endmodule
